// File: rtl/pwm_counter_ctrl.sv
// PWM/timer sequencer: owns the main counter, the period/duty shadow registers,
// the IDLE/RUN/DONE state machine and the sticky interrupt flag.
module pwm_counter_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             chosen_clk,
   input  logic             rst,
   input  logic             counter_en,
   input  logic             mode,
   input  logic             one_shot,
   input  logic             cnt_clr,
   input  logic             irq_en,
   input  logic             irq_clr,
   input  logic             cfg_wr,
   input  logic [CNT_W-1:0] period_in,
   input  logic [CNT_W-1:0] dc_in,
   output logic [CNT_W-1:0] counter,
   output logic [CNT_W-1:0] period_shadow,
   output logic [CNT_W-1:0] dc_shadow,
   output logic             pwm_en,
   output logic             wrap,
   output logic             done,
   output logic             irq_flag,
   output logic             irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] counter_q, counter_d;
   logic [CNT_W-1:0] period_shadow_q, period_shadow_d;
   logic [CNT_W-1:0] dc_shadow_q, dc_shadow_d;
   logic             upd_pend_q, upd_pend_d;
   logic             wrap_q, wrap_d;
   logic             irq_flag_q, irq_flag_d;

   logic [CNT_W-1:0] last_cnt;
   logic             at_boundary;
   logic             boundary;

   // A zero period can only arrive through a pending update; it is treated
   // as a boundary on every cycle so the counter never runs away.
   assign last_cnt    = period_shadow_q - CNT_W'(1);
   assign at_boundary = (period_shadow_q == '0) || (counter_q == last_cnt);

   always_comb begin
      state_d         = state_q;
      counter_d       = counter_q;
      period_shadow_d = period_shadow_q;
      dc_shadow_d     = dc_shadow_q;
      upd_pend_d      = upd_pend_q;
      boundary        = 1'b0;

      case (state_q)
         IDLE: begin
            counter_d       = '0;
            period_shadow_d = period_in;
            dc_shadow_d     = dc_in;
            upd_pend_d      = 1'b0;
            if (counter_en && (period_in != '0)) begin
               state_d = RUN;
            end
         end

         RUN: begin
            if (!counter_en) begin
               state_d    = IDLE;
               counter_d  = '0;
               upd_pend_d = 1'b0;
            end else begin
               if (cfg_wr) begin
                  upd_pend_d = 1'b1;
               end
               if (cnt_clr) begin
                  counter_d = '0;
               end else if (at_boundary) begin
                  boundary = 1'b1;
                  // A write landing on the boundary cycle is taken directly.
                  if (upd_pend_q || cfg_wr) begin
                     period_shadow_d = period_in;
                     dc_shadow_d     = dc_in;
                     upd_pend_d      = 1'b0;
                  end
                  if (one_shot) begin
                     state_d = DONE;
                  end else begin
                     counter_d = '0;
                  end
               end else begin
                  counter_d = counter_q + CNT_W'(1);
               end
            end
         end

         DONE: begin
            if (cfg_wr) begin
               upd_pend_d = 1'b1;
            end
            if (!counter_en) begin
               state_d    = IDLE;
               counter_d  = '0;
               upd_pend_d = 1'b0;
            end else if (!one_shot) begin
               state_d   = RUN;
               counter_d = '0;
            end else if (cnt_clr) begin
               counter_d = '0;
            end
         end

         default: begin
            state_d   = IDLE;
            counter_d = '0;
         end
      endcase

      wrap_d     = boundary;
      irq_flag_d = boundary | (irq_flag_q & ~irq_clr);
   end

   always_ff @(posedge chosen_clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         counter_q       <= '0;
         period_shadow_q <= '0;
         dc_shadow_q     <= '0;
         upd_pend_q      <= 1'b0;
         wrap_q          <= 1'b0;
         irq_flag_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         counter_q       <= counter_d;
         period_shadow_q <= period_shadow_d;
         dc_shadow_q     <= dc_shadow_d;
         upd_pend_q      <= upd_pend_d;
         wrap_q          <= wrap_d;
         irq_flag_q      <= irq_flag_d;
      end
   end

   assign counter       = counter_q;
   assign period_shadow = period_shadow_q;
   assign dc_shadow     = dc_shadow_q;
   assign wrap          = wrap_q;
   assign done          = (state_q == DONE);
   assign pwm_en        = mode && (state_q == RUN) && (period_shadow_q != '0);
   assign irq_flag      = irq_flag_q;
   assign irq           = irq_flag_q & irq_en;

endmodule

// File: tb/tb_pwm_counter_ctrl.sv
// Directed bench for pwm_counter_ctrl: continuous, one-shot, deferred config,
// counter clear, irq clear/set priority, zero period and async reset.
module tb_pwm_counter_ctrl;

   logic        clk;
   logic        rst;
   logic        counter_en, mode, one_shot, cnt_clr, irq_en, irq_clr, cfg_wr;
   logic [15:0] period_in, dc_in;
   logic [15:0] counter, period_shadow, dc_shadow;
   logic        pwm_en, wrap, done, irq_flag, irq;

   int checks = 0;
   int errors = 0;

   pwm_counter_ctrl #(.CNT_W(16)) dut (
      .chosen_clk    (clk),
      .rst           (rst),
      .counter_en    (counter_en),
      .mode          (mode),
      .one_shot      (one_shot),
      .cnt_clr       (cnt_clr),
      .irq_en        (irq_en),
      .irq_clr       (irq_clr),
      .cfg_wr        (cfg_wr),
      .period_in     (period_in),
      .dc_in         (dc_in),
      .counter       (counter),
      .period_shadow (period_shadow),
      .dc_shadow     (dc_shadow),
      .pwm_en        (pwm_en),
      .wrap          (wrap),
      .done          (done),
      .irq_flag      (irq_flag),
      .irq           (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      rst = 1'b1;
      counter_en = 1'b0; mode = 1'b0; one_shot = 1'b0; cnt_clr = 1'b0;
      irq_en = 1'b0; irq_clr = 1'b0; cfg_wr = 1'b0;
      period_in = 16'd0; dc_in = 16'd0;
      tick();
      tick();
      chk("rst_counter", 32'(counter), 32'd0);
      chk("rst_period", 32'(period_shadow), 32'd0);
      chk("rst_dc", 32'(dc_shadow), 32'd0);
      chk("rst_pwm_en", 32'(pwm_en), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_irq_flag", 32'(irq_flag), 32'd0);

      // Test 1: continuous PWM, period 4
      period_in = 16'd4; dc_in = 16'd2; mode = 1'b1; counter_en = 1'b1; irq_en = 1'b1;
      rst = 1'b0;
      tick();
      chk("t1_start_cnt", 32'(counter), 32'd0);
      chk("t1_period", 32'(period_shadow), 32'd4);
      chk("t1_dc", 32'(dc_shadow), 32'd2);
      chk("t1_pwm_en", 32'(pwm_en), 32'd1);
      chk("t1_irq0", 32'(irq_flag), 32'd0);
      for (int k = 2; k <= 9; k++) begin
         tick();
         chk($sformatf("t1_cnt_%0d", k), 32'(counter), 32'((k - 1) % 4));
         chk($sformatf("t1_wrap_%0d", k), 32'(wrap), 32'((k >= 5) && ((k - 1) % 4 == 0)));
         chk($sformatf("t1_irqf_%0d", k), 32'(irq_flag), 32'(k >= 5));
      end
      chk("t1_irq", 32'(irq), 32'd1);

      // Test 2: one-shot, period 5
      counter_en = 1'b0;
      tick();
      chk("t2_idle_cnt", 32'(counter), 32'd0);
      chk("t2_idle_wrap", 32'(wrap), 32'd0);
      chk("t2_idle_pwm", 32'(pwm_en), 32'd0);
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      chk("t2_irq_clr", 32'(irq_flag), 32'd0);
      period_in = 16'd5; one_shot = 1'b1; counter_en = 1'b1;
      tick();
      chk("t2_cnt0", 32'(counter), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("t2_cnt%0d", k), 32'(counter), 32'(k));
         chk($sformatf("t2_done%0d", k), 32'(done), 32'd0);
      end
      tick();
      chk("t2_done_cnt", 32'(counter), 32'd4);
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_done_wrap", 32'(wrap), 32'd1);
      chk("t2_done_irq", 32'(irq), 32'd1);
      chk("t2_done_pwm", 32'(pwm_en), 32'd0);
      tick();
      chk("t2_hold_cnt", 32'(counter), 32'd4);
      chk("t2_hold_done", 32'(done), 32'd1);
      chk("t2_hold_wrap", 32'(wrap), 32'd0);
      counter_en = 1'b0;
      tick();
      chk("t2_exit_cnt", 32'(counter), 32'd0);
      chk("t2_exit_done", 32'(done), 32'd0);

      // Test 3: deferred period update
      one_shot = 1'b0; period_in = 16'd8; counter_en = 1'b1;
      tick();
      tick();
      tick();
      chk("t3_cnt2", 32'(counter), 32'd2);
      cfg_wr = 1'b1; period_in = 16'd3;
      tick();
      cfg_wr = 1'b0;
      chk("t3_cnt3", 32'(counter), 32'd3);
      chk("t3_per_hold", 32'(period_shadow), 32'd8);
      for (int k = 4; k <= 7; k++) begin
         tick();
         chk($sformatf("t3_cnt%0d", k), 32'(counter), 32'(k));
         chk($sformatf("t3_per%0d", k), 32'(period_shadow), 32'd8);
      end
      tick();
      chk("t3_wrap_cnt", 32'(counter), 32'd0);
      chk("t3_wrap", 32'(wrap), 32'd1);
      chk("t3_per_new", 32'(period_shadow), 32'd3);
      tick();
      chk("t3_n1", 32'(counter), 32'd1);
      tick();
      chk("t3_n2", 32'(counter), 32'd2);
      tick();
      chk("t3_n0", 32'(counter), 32'd0);
      chk("t3_n0_wrap", 32'(wrap), 32'd1);

      // Test 4: cnt_clr and irq clear vs set
      counter_en = 1'b0;
      tick();
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      chk("t4_irq_clr", 32'(irq_flag), 32'd0);
      period_in = 16'd10; counter_en = 1'b1;
      tick();
      for (int k = 1; k <= 5; k++) tick();
      chk("t4_cnt5", 32'(counter), 32'd5);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("t4_clr_cnt", 32'(counter), 32'd0);
      chk("t4_clr_wrap", 32'(wrap), 32'd0);
      chk("t4_clr_irq", 32'(irq_flag), 32'd0);
      for (int k = 1; k <= 9; k++) tick();
      chk("t4_cnt9", 32'(counter), 32'd9);
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      chk("t4_wrap_cnt", 32'(counter), 32'd0);
      chk("t4_wrap", 32'(wrap), 32'd1);
      chk("t4_set_wins", 32'(irq_flag), 32'd1);

      // Test 5: zero period, then async reset mid-run
      counter_en = 1'b0;
      tick();
      period_in = 16'd0; counter_en = 1'b1;
      tick();
      chk("t5_zero_pwm", 32'(pwm_en), 32'd0);
      chk("t5_zero_cnt", 32'(counter), 32'd0);
      tick();
      chk("t5_zero_pwm2", 32'(pwm_en), 32'd0);
      chk("t5_zero_cnt2", 32'(counter), 32'd0);
      period_in = 16'd10;
      tick();
      chk("t5_run_pwm", 32'(pwm_en), 32'd1);
      for (int k = 1; k <= 6; k++) tick();
      chk("t5_cnt6", 32'(counter), 32'd6);
      chk("t5_pre_irq", 32'(irq_flag), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_arst_cnt", 32'(counter), 32'd0);
      chk("t5_arst_per", 32'(period_shadow), 32'd0);
      chk("t5_arst_dc", 32'(dc_shadow), 32'd0);
      chk("t5_arst_pwm", 32'(pwm_en), 32'd0);
      chk("t5_arst_irq", 32'(irq_flag), 32'd0);
      chk("t5_arst_done", 32'(done), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("t5_restart_cnt", 32'(counter), 32'd0);
      chk("t5_restart_pwm", 32'(pwm_en), 32'd1);
      tick();
      chk("t5_restart_cnt1", 32'(counter), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
